gemm_c_drain: RTL

Read-side companion to the GeMM accelerator's C-output path. After a GeMM completes, this block walks the block-packed output SRAM C (one 4x4 int32 tile per word) and streams the result matrix out one element per beat in global row-major order over a valid/ready interface. It sits between the C memory's read port and a host/readback stream, and unpacks exactly the layout the accelerator writes.

---
 rtl/gemm_pkg.sv | 28 ++
 rtl/gemm_c_drain.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/gemm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gemm_pkg
// Purpose  : Shared types and default geometry for the GeMM C-output path.
// Revision : 1.0  initial release
// ============================================================================
package gemm_pkg;

    localparam int GEMM_OUT_DATA_W  = 32;
    localparam int GEMM_MESH_ROW    = 4;
    localparam int GEMM_MESH_COL    = 4;
    localparam int GEMM_ADDR_W      = 12;
    localparam int GEMM_SIZE_ADDR_W = 8;

    localparam int GEMM_SRAM_C_W    = GEMM_MESH_ROW * GEMM_MESH_COL * GEMM_OUT_DATA_W;
    localparam int GEMM_ROW_IDX_W   = GEMM_SIZE_ADDR_W + $clog2(GEMM_MESH_ROW);
    localparam int GEMM_COL_IDX_W   = GEMM_SIZE_ADDR_W + $clog2(GEMM_MESH_COL);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LATCH = 3'd2,
        S_EMIT  = 3'd3,
        S_DONE  = 3'd4
    } drain_state_e;

endpackage
`default_nettype wire

// File: rtl/gemm_c_drain.sv
`default_nettype none
// ============================================================================
// Module   : gemm_c_drain
// Purpose  : Walks block-packed SRAM C and streams the result matrix out one
//            element per beat in global row-major order.
// Revision : 1.0  initial release
// ============================================================================
module gemm_c_drain
    import gemm_pkg::*;
#(
    parameter int OutDataWidth  = GEMM_OUT_DATA_W,
    parameter int meshRow       = GEMM_MESH_ROW,
    parameter int meshCol       = GEMM_MESH_COL,
    parameter int AddrWidth     = GEMM_ADDR_W,
    parameter int SizeAddrWidth = GEMM_SIZE_ADDR_W,
    localparam int SRAM_C_Width = meshRow * meshCol * OutDataWidth
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic                                      start_i,
    input  logic [SizeAddrWidth-1:0]                  M_size_i,
    input  logic [SizeAddrWidth-1:0]                  N_size_i,
    output logic [AddrWidth-1:0]                      sram_c_addr_o,
    input  logic [SRAM_C_Width-1:0]                   sram_c_rdata_i,
    output logic [OutDataWidth-1:0]                   out_data_o,
    output logic [SizeAddrWidth+$clog2(meshRow)-1:0]  out_row_o,
    output logic [SizeAddrWidth+$clog2(meshCol)-1:0]  out_col_o,
    output logic                                      out_valid_o,
    input  logic                                      out_ready_i,
    output logic                                      out_last_o,
    output logic                                      busy_o,
    output logic                                      done_o
);

    localparam int RW       = (meshRow > 1) ? $clog2(meshRow) : 1;
    localparam int CW       = (meshCol > 1) ? $clog2(meshCol) : 1;
    localparam int ROW_W    = SizeAddrWidth + $clog2(meshRow);
    localparam int COL_W    = SizeAddrWidth + $clog2(meshCol);
    localparam int ROW_BITS = meshCol * OutDataWidth;

    drain_state_e state, state_nx;

    logic [SizeAddrWidth-1:0] m_size, n_size;
    logic [SizeAddrWidth-1:0] m_cnt, n_cnt, m_nx, n_nx;
    logic [RW-1:0]            r_cnt, r_nx;
    logic [CW-1:0]            c_cnt;
    logic [ROW_BITS-1:0]      row_q;
    logic [AddrWidth-1:0]     addr_nx;

    logic c_last, n_last, r_last, m_last;
    logic beat, chunk_end, final_beat, sizes_ok;

    always_comb begin
        c_last     = (c_cnt == CW'(meshCol - 1));
        n_last     = (n_cnt == n_size - SizeAddrWidth'(1));
        r_last     = (r_cnt == RW'(meshRow - 1));
        m_last     = (m_cnt == m_size - SizeAddrWidth'(1));
        beat       = (state == S_EMIT) && out_ready_i;
        chunk_end  = beat && c_last;
        final_beat = chunk_end && n_last && r_last && m_last;
        sizes_ok   = (M_size_i != '0) && (N_size_i != '0);

        // Coordinates of the next tile-row chunk: n fastest, then r, then m.
        n_nx = n_last ? '0 : n_cnt + SizeAddrWidth'(1);
        r_nx = r_cnt;
        m_nx = m_cnt;
        if (n_last) begin
            if (r_last) begin
                r_nx = '0;
                m_nx = m_cnt + SizeAddrWidth'(1);
            end else begin
                r_nx = r_cnt + RW'(1);
            end
        end
        addr_nx = AddrWidth'(m_nx) * AddrWidth'(n_size) + AddrWidth'(n_nx);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start_i) state_nx = sizes_ok ? S_READ : S_DONE;
            S_READ:  state_nx = S_LATCH;
            S_LATCH: state_nx = S_EMIT;
            S_EMIT:  if (chunk_end) state_nx = final_beat ? S_DONE : S_READ;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m_size        <= '0;
            n_size        <= '0;
            m_cnt         <= '0;
            n_cnt         <= '0;
            r_cnt         <= '0;
            c_cnt         <= '0;
            row_q         <= '0;
            sram_c_addr_o <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        m_size <= M_size_i;
                        n_size <= N_size_i;
                        m_cnt  <= '0;
                        n_cnt  <= '0;
                        r_cnt  <= '0;
                        c_cnt  <= '0;
                        if (sizes_ok) begin
                            sram_c_addr_o <= '0;
                        end
                    end
                end
                S_LATCH: begin
                    row_q <= sram_c_rdata_i[int'(r_cnt)*ROW_BITS +: ROW_BITS];
                end
                S_EMIT: begin
                    if (beat) begin
                        if (c_last) begin
                            c_cnt <= '0;
                            // Address for the next chunk is ready as READ begins.
                            if (!final_beat) begin
                                m_cnt         <= m_nx;
                                n_cnt         <= n_nx;
                                r_cnt         <= r_nx;
                                sram_c_addr_o <= addr_nx;
                            end
                        end else begin
                            c_cnt <= c_cnt + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid_o = (state == S_EMIT);
    assign out_last_o  = out_valid_o && c_last && n_last && r_last && m_last;
    assign busy_o      = (state != S_IDLE);
    assign done_o      = (state == S_DONE);
    assign out_data_o  = row_q[int'(c_cnt)*OutDataWidth +: OutDataWidth];
    assign out_row_o   = ROW_W'(m_cnt) * ROW_W'(meshRow) + ROW_W'(r_cnt);
    assign out_col_o   = COL_W'(n_cnt) * COL_W'(meshCol) + COL_W'(c_cnt);

endmodule
`default_nettype wire
